dzcpu_uop_sequencer: RTL and testbench

DZCPU_UOP_SEQUENCER -- requirements
Module: dzcpu_uop_sequencer

---
 rtl/dzcpu_uop_sequencer.sv | 155 +++++++++++++++
 tb/tb_dzcpu_uop_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dzcpu_uop_sequencer.sv
// Micro-op sequencer: fetches an opcode, dispatches through the main or 0xCB LUT and walks the uop ROM.
// Optional watchdog on runaway flows: define DZCPU_USEQ_WATCHDOG_EN.
`timescale 1ns/1ps
module dzcpu_uop_sequencer (
    input  logic       iClock,
    input  logic       iReset,
    input  logic [7:0] iMop,
    input  logic       iMopValid,
    input  logic [7:0] iFlowIdx,
    input  logic [7:0] iCbFlowIdx,
    input  logic [2:0] iUopCtl,
    input  logic       iUopJcb,
    input  logic       iFlagZ,
    output logic [7:0] oMop,
    output logic [7:0] oUopAddr,
    output logic       oUopValid,
    output logic       oIncPc,
    output logic       oUpdateFlags,
    output logic       oFetchReq,
    output logic       oCbMode,
    output logic       oError
);

    localparam logic [2:0] CTL_OP         = 3'd0;
    localparam logic [2:0] CTL_INC        = 3'd1;
    localparam logic [2:0] CTL_EOF        = 3'd2;
    localparam logic [2:0] CTL_INC_EOF    = 3'd3;
    localparam logic [2:0] CTL_INC_EOF_Z  = 3'd4;
    localparam logic [2:0] CTL_INC_EOF_NZ = 3'd5;
    localparam logic [2:0] CTL_EOF_FU     = 3'd6;
    localparam logic [2:0] CTL_INC_EOF_FU = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EXEC,
        S_CB_WAIT,
        S_CB_LOOKUP
    } state_t;

    state_t     r_state;
    logic [7:0] r_upc;
    logic [7:0] r_mop;
    logic       r_cb_mode;

    logic w_exec;
    logic w_inc_class;
    logic w_fu_class;
    logic w_terminate;
    logic w_wd_trip;

    assign w_exec = (r_state == S_EXEC);

    // Decode of the current uop control field
    always_comb begin
        w_inc_class = 1'b0;
        w_fu_class  = 1'b0;
        w_terminate = 1'b0;
        case (iUopCtl)
            CTL_OP:         ;
            CTL_INC:        w_inc_class = 1'b1;
            CTL_EOF:        w_terminate = 1'b1;
            CTL_INC_EOF:    begin w_inc_class = 1'b1; w_terminate = 1'b1; end
            CTL_INC_EOF_Z:  begin w_inc_class = 1'b1; w_terminate = iFlagZ; end
            CTL_INC_EOF_NZ: begin w_inc_class = 1'b1; w_terminate = ~iFlagZ; end
            CTL_EOF_FU:     begin w_fu_class = 1'b1; w_terminate = 1'b1; end
            CTL_INC_EOF_FU: begin w_inc_class = 1'b1; w_fu_class = 1'b1; w_terminate = 1'b1; end
            default:        ;
        endcase
    end

`ifdef DZCPU_USEQ_WATCHDOG_EN
    localparam int unsigned WD_W     = 6;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(47);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_error;

    // Counts uops since flow entry; trips on the 48th uop that neither ends nor jumps
    assign w_wd_trip = (r_wd_cnt == WD_LAST);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_wd_cnt <= '0;
            r_error  <= 1'b0;
        end else if (r_state == S_LOOKUP || r_state == S_CB_LOOKUP) begin
            r_wd_cnt <= '0;
        end else if (w_exec) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
            if (w_wd_trip && !iUopJcb && !w_terminate)
                r_error <= 1'b1;
        end
    end

    assign oError = r_error;
`else
    assign w_wd_trip = 1'b0;
    assign oError    = 1'b0;
`endif

    // Sequencer state, uPC, latched opcode and CB mode
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state   <= S_IDLE;
            r_upc     <= 8'h00;
            r_mop     <= 8'h00;
            r_cb_mode <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cb_mode <= 1'b0;
                    if (iMopValid) begin
                        r_mop   <= iMop;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_upc   <= iFlowIdx;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (iUopJcb) begin
                        r_cb_mode <= 1'b1;
                        r_state   <= S_CB_WAIT;
                    end else if (w_terminate || w_wd_trip) begin
                        r_cb_mode <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_upc <= r_upc + 8'd1;
                    end
                end
                S_CB_WAIT: begin
                    if (iMopValid) begin
                        r_mop   <= iMop;
                        r_state <= S_CB_LOOKUP;
                    end
                end
                S_CB_LOOKUP: begin
                    r_upc   <= iCbFlowIdx;
                    r_state <= S_EXEC;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oMop         = r_mop;
    assign oUopAddr     = r_upc;
    assign oUopValid    = w_exec;
    assign oIncPc       = w_exec & w_inc_class;
    assign oUpdateFlags = w_exec & w_fu_class;
    assign oFetchReq    = (r_state == S_IDLE) || (r_state == S_CB_WAIT);
    assign oCbMode      = r_cb_mode;

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer: LUT/ROM models drive the DUT, a scoreboard checks every executed uop.
`timescale 1ns/1ps
module tb_dzcpu_uop_sequencer;

    logic       iClock = 1'b0;
    logic       iReset;
    logic [7:0] iMop;
    logic       iMopValid;
    logic [7:0] iFlowIdx;
    logic [7:0] iCbFlowIdx;
    logic [2:0] iUopCtl;
    logic       iUopJcb;
    logic       iFlagZ;
    logic [7:0] oMop;
    logic [7:0] oUopAddr;
    logic       oUopValid;
    logic       oIncPc;
    logic       oUpdateFlags;
    logic       oFetchReq;
    logic       oCbMode;
    logic       oError;

    dzcpu_uop_sequencer dut (
        .iClock(iClock), .iReset(iReset), .iMop(iMop), .iMopValid(iMopValid),
        .iFlowIdx(iFlowIdx), .iCbFlowIdx(iCbFlowIdx), .iUopCtl(iUopCtl),
        .iUopJcb(iUopJcb), .iFlagZ(iFlagZ), .oMop(oMop), .oUopAddr(oUopAddr),
        .oUopValid(oUopValid), .oIncPc(oIncPc), .oUpdateFlags(oUpdateFlags),
        .oFetchReq(oFetchReq), .oCbMode(oCbMode), .oError(oError)
    );

    always #5 iClock = ~iClock;

    // LUT and uop ROM models seen by the DUT
    logic [7:0] flow_lut [256];
    logic [7:0] cb_lut   [256];
    logic [2:0] ctl_rom  [256];
    logic       jcb_rom  [256];

    assign iFlowIdx   = flow_lut[oMop];
    assign iCbFlowIdx = cb_lut[oMop];
    assign iUopCtl    = ctl_rom[oUopAddr];
    assign iUopJcb    = jcb_rom[oUopAddr];

    typedef struct packed {
        logic [7:0] addr;
        logic       inc;
        logic       fu;
        logic       cb;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] addr, input logic inc, input logic fu, input logic cb);
        exp_t e;
        e.addr = addr; e.inc = inc; e.fu = fu; e.cb = cb;
        sb.push_back(e);
    endtask

    // Every executing uop is popped from the scoreboard and compared
    always @(negedge iClock) begin
        if (oUopValid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_uop", {24'd0, oUopAddr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("uop_addr", {24'd0, oUopAddr}, {24'd0, e.addr});
                chk("uop_incpc", {31'd0, oIncPc}, {31'd0, e.inc});
                chk("uop_flags", {31'd0, oUpdateFlags}, {31'd0, e.fu});
                chk("uop_cbmode", {31'd0, oCbMode}, {31'd0, e.cb});
            end
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic issue(input logic [7:0] mop);
        iMop      = mop;
        iMopValid = 1'b1;
        tick();
        iMopValid = 1'b0;
    endtask

    task automatic wait_fetch(input string tag, input int budget);
        int n = 0;
        while (oFetchReq !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, oFetchReq}, 32'd1);
    endtask

    task automatic wait_cb(input string tag, input int budget);
        int n = 0;
        while (oCbMode !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, oCbMode}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            flow_lut[i] = 8'h00;
            cb_lut[i]   = 8'h00;
            ctl_rom[i]  = 3'd0;
            jcb_rom[i]  = 1'b0;
        end
        flow_lut[8'h05] = 8'd5;
        flow_lut[8'h11] = 8'd17;
        flow_lut[8'hCB] = 8'd13;
        flow_lut[8'h64] = 8'd100;
        cb_lut[8'h7C]   = 8'd16;
        ctl_rom[0]  = 3'd3;
        ctl_rom[5]  = 3'd1; ctl_rom[6]  = 3'd1; ctl_rom[7] = 3'd0; ctl_rom[8] = 3'd3;
        ctl_rom[13] = 3'd0; ctl_rom[14] = 3'd0; ctl_rom[15] = 3'd0; jcb_rom[15] = 1'b1;
        ctl_rom[16] = 3'd6;
        ctl_rom[17] = 3'd0; ctl_rom[18] = 3'd0; ctl_rom[19] = 3'd4;
        ctl_rom[20] = 3'd1; ctl_rom[21] = 3'd0; ctl_rom[22] = 3'd2;

        iReset = 1'b1; iMop = 8'h00; iMopValid = 1'b0; iFlagZ = 1'b0;
        tick(); tick();
        iReset = 1'b0;
        chk("rst_fetchreq", {31'd0, oFetchReq}, 32'd1);
        chk("rst_uopvalid", {31'd0, oUopValid}, 32'd0);
        chk("rst_upc", {24'd0, oUopAddr}, 32'd0);
        chk("rst_mop", {24'd0, oMop}, 32'd0);
        chk("rst_cbmode", {31'd0, oCbMode}, 32'd0);
        chk("rst_error", {31'd0, oError}, 32'd0);
        chk("rst_incpc", {31'd0, oIncPc}, 32'd0);

        // Single-uop flow at index 0
        push(8'd0, 1'b1, 1'b0, 1'b0);
        issue(8'h00);
        chk("s1_lookup_valid", {31'd0, oUopValid}, 32'd0);
        chk("s1_lookup_fetch", {31'd0, oFetchReq}, 32'd0);
        tick();
        chk("s1_exec_valid", {31'd0, oUopValid}, 32'd1);
        tick();
        chk("s1_fetch_cycle3", {31'd0, oFetchReq}, 32'd1);
        chk("s1_idle_incpc", {31'd0, oIncPc}, 32'd0);
        chk("s1_sb_empty", sb.size(), 32'd0);

        // Multi-uop flow; opcode strobes during the flow must be ignored
        push(8'd5, 1'b1, 1'b0, 1'b0); push(8'd6, 1'b1, 1'b0, 1'b0);
        push(8'd7, 1'b0, 1'b0, 1'b0); push(8'd8, 1'b1, 1'b0, 1'b0);
        issue(8'h05);
        iMop = 8'h99; iMopValid = 1'b1;
        wait_fetch("s2_end", 20);
        iMopValid = 1'b0;
        chk("s2_mop_held", {24'd0, oMop}, 32'h05);
        chk("s2_sb_empty", sb.size(), 32'd0);

        // Conditional termination, Z set
        iFlagZ = 1'b1;
        push(8'd17, 1'b0, 1'b0, 1'b0); push(8'd18, 1'b0, 1'b0, 1'b0); push(8'd19, 1'b1, 1'b0, 1'b0);
        issue(8'h11);
        wait_fetch("s3z_end", 20);
        chk("s3z_upc", {24'd0, oUopAddr}, 32'd19);
        chk("s3z_sb_empty", sb.size(), 32'd0);

        // Conditional termination, Z clear
        iFlagZ = 1'b0;
        push(8'd17, 1'b0, 1'b0, 1'b0); push(8'd18, 1'b0, 1'b0, 1'b0); push(8'd19, 1'b1, 1'b0, 1'b0);
        push(8'd20, 1'b1, 1'b0, 1'b0); push(8'd21, 1'b0, 1'b0, 1'b0); push(8'd22, 1'b0, 1'b0, 1'b0);
        issue(8'h11);
        wait_fetch("s3nz_end", 20);
        chk("s3nz_upc", {24'd0, oUopAddr}, 32'd22);
        chk("s3nz_sb_empty", sb.size(), 32'd0);

        // CB dispatch with an extended wait for the second opcode
        push(8'd13, 1'b0, 1'b0, 1'b0); push(8'd14, 1'b0, 1'b0, 1'b0);
        push(8'd15, 1'b0, 1'b0, 1'b0); push(8'd16, 1'b0, 1'b1, 1'b1);
        issue(8'hCB);
        wait_cb("s4_cbwait", 20);
        tick(); tick(); tick();
        chk("s4_wait_valid", {31'd0, oUopValid}, 32'd0);
        chk("s4_wait_cbmode", {31'd0, oCbMode}, 32'd1);
        issue(8'h7C);
        chk("s4_cblookup_valid", {31'd0, oUopValid}, 32'd0);
        chk("s4_cblookup_mop", {24'd0, oMop}, 32'h7C);
        tick();
        chk("s4_exec_flags", {31'd0, oUpdateFlags}, 32'd1);
        tick();
        chk("s4_idle_fetch", {31'd0, oFetchReq}, 32'd1);
        chk("s4_idle_cbmode", {31'd0, oCbMode}, 32'd0);
        chk("s4_sb_empty", sb.size(), 32'd0);

        // Reset on the second EXEC cycle
        push(8'd17, 1'b0, 1'b0, 1'b0); push(8'd18, 1'b0, 1'b0, 1'b0);
        issue(8'h11);
        tick();
        tick();
        chk("s5_second_exec", {24'd0, oUopAddr}, 32'd18);
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        chk("s5_fetch", {31'd0, oFetchReq}, 32'd1);
        chk("s5_upc", {24'd0, oUopAddr}, 32'd0);
        chk("s5_incpc", {31'd0, oIncPc}, 32'd0);
        chk("s5_valid", {31'd0, oUopValid}, 32'd0);
        chk("s5_mop", {24'd0, oMop}, 32'd0);
        tick();
        chk("s5_stays_idle", {31'd0, oUopValid}, 32'd0);
        chk("s5_sb_empty", sb.size(), 32'd0);

        // Reset while waiting for the CB opcode
        push(8'd13, 1'b0, 1'b0, 1'b0); push(8'd14, 1'b0, 1'b0, 1'b0); push(8'd15, 1'b0, 1'b0, 1'b0);
        issue(8'hCB);
        wait_cb("s6_cbwait", 20);
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        chk("s6_cbmode", {31'd0, oCbMode}, 32'd0);
        chk("s6_upc", {24'd0, oUopAddr}, 32'd0);
        chk("s6_sb_empty", sb.size(), 32'd0);

        // Long all-OP flow from index 100: watchdog trip, or wrap past 255
        for (int i = 0; i < 256; i++) begin
            ctl_rom[i] = 3'd0;
            jcb_rom[i] = 1'b0;
        end
`ifdef DZCPU_USEQ_WATCHDOG_EN
        for (int i = 100; i < 148; i++) push(8'(i), 1'b0, 1'b0, 1'b0);
        issue(8'h64);
        wait_fetch("s7_wd_end", 200);
        chk("s7_error", {31'd0, oError}, 32'd1);
        chk("s7_cbmode", {31'd0, oCbMode}, 32'd0);
        chk("s7_upc", {24'd0, oUopAddr}, 32'd147);
        chk("s7_sb_empty", sb.size(), 32'd0);
        tick(); tick();
        chk("s7_error_sticky", {31'd0, oError}, 32'd1);
`else
        ctl_rom[2] = 3'd2;
        for (int i = 100; i < 256; i++) push(8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(8'(i), 1'b0, 1'b0, 1'b0);
        issue(8'h64);
        wait_fetch("s7_wrap_end", 300);
        chk("s7_error", {31'd0, oError}, 32'd0);
        chk("s7_upc", {24'd0, oUopAddr}, 32'd2);
        chk("s7_sb_empty", sb.size(), 32'd0);
`endif
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        chk("s8_error_cleared", {31'd0, oError}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
